// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory refill arbiter: FSM states, owner encoding
// and the default cache-line size in words.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int LINE_WORDS_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between ICache and DCache; remembers which side
// finished the last burst so a tie goes to the other side.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  input  logic done_owner,
  output logic grant_valid,
  output logic grant_owner
);

  logic last_owner;

  // Reset to OWNER_I so the DCache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWNER_I;
    end else if (update) begin
      last_owner <= done_owner;
    end
  end

  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWNER_I;
    if (req_i && req_d) begin
      grant_owner = ~last_owner;
    end else if (req_d) begin
      grant_owner = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one main-memory port between the ICache and DCache refill paths, one
// LINE_WORDS-beat burst per grant. Define MEM_ARB_PERF_CNT_EN for perf counters.
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_we,
  input  logic [31:0]       i_wdata,
  output logic [BEAT_W-1:0] i_beat,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  output logic [BEAT_W-1:0] d_beat,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]       perf_i_bursts,
  output logic [31:0]       perf_d_bursts,
  output logic [31:0]       perf_wait_cycles,
`endif
  output arb_state_e        dbg_state
);

  // Handshakes: cache *_req is a level held until its *_done pulse; mem_req is
  // held with stable addr/we/wdata until mem_ack, and each mem_ack ends one beat.

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q;
  logic [BEAT_W-1:0] beat_q, rd_beat_q, own_beat;
  logic              grant_valid, grant_owner;
  logic [31:0]       own_addr, own_wdata;
  logic              own_we, rd_ack;
  logic              i_rvalid_q, d_rvalid_q;
  logic [31:0]       i_rdata_q, d_rdata_q;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (i_req),
    .req_d       (d_req),
    .update      (state_q == DONE),
    .done_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    own_addr  = (owner_q == OWNER_D) ? d_addr  : i_addr;
    own_we    = (owner_q == OWNER_D) ? d_we    : i_we;
    own_wdata = (owner_q == OWNER_D) ? d_wdata : i_wdata;
    rd_ack    = (state_q == BUSY) && mem_ack && !own_we;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = BUSY;
      BUSY:    if (mem_ack && beat_q == LAST_BEAT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_I;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_valid) begin
        owner_q <= grant_owner;
      end
      // The beat only wraps on the way back to IDLE, never inside a burst.
      if (state_q == BUSY && mem_ack && beat_q != LAST_BEAT) begin
        beat_q <= beat_q + 1'b1;
      end else if (state_q == DONE) begin
        beat_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      rd_beat_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= rd_ack && (owner_q == OWNER_I);
      d_rvalid_q <= rd_ack && (owner_q == OWNER_D);
      if (rd_ack) begin
        rd_beat_q <= beat_q;
      end
      if (rd_ack && owner_q == OWNER_I) begin
        i_rdata_q <= mem_rdata;
      end
      if (rd_ack && owner_q == OWNER_D) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_req   = (state_q == BUSY);
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == BUSY) begin
      mem_addr  = {own_addr[31:2+BEAT_W], beat_q, 2'b00};
      mem_we    = own_we;
      mem_wdata = own_wdata;
    end
    // While read data is returned, the beat output names the beat it belongs to.
    own_beat = (i_rvalid_q || d_rvalid_q) ? rd_beat_q : beat_q;
    i_beat   = '0;
    d_beat   = '0;
    if (state_q != IDLE) begin
      if (owner_q == OWNER_I) i_beat = own_beat;
      else                    d_beat = own_beat;
    end
    i_done    = (state_q == DONE) && (owner_q == OWNER_I);
    d_done    = (state_q == DONE) && (owner_q == OWNER_D);
    i_rvalid  = i_rvalid_q;
    d_rvalid  = d_rvalid_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    dbg_state = state_q;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic waiting;

  // A requester waits while the other side owns the port, or loses a tie in IDLE.
  always_comb begin
    waiting = 1'b0;
    if (state_q == IDLE)          waiting = i_req && d_req;
    else if (owner_q == OWNER_I)  waiting = d_req;
    else                          waiting = i_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_bursts    <= '0;
      perf_d_bursts    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state_q == DONE && owner_q == OWNER_I && perf_i_bursts != '1) begin
        perf_i_bursts <= perf_i_bursts + 1'b1;
      end
      if (state_q == DONE && owner_q == OWNER_D && perf_d_bursts != '1) begin
        perf_d_bursts <= perf_d_bursts + 1'b1;
      end
      if (waiting && perf_wait_cycles != '1) begin
        perf_wait_cycles <= perf_wait_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomized scoreboard bench for mem_refill_arbiter: a memory model with
// variable ack latency, cache drivers, and a monitor checking every beat.
module tb_mem_refill_arbiter;
  import mem_arb_pkg::*;

  localparam int LW       = 4;
  localparam int BW       = 2;
  localparam int MAX_WAIT = 400;

  logic          clk, rst;
  logic          i_req, i_we, d_req, d_we;
  logic [31:0]   i_addr, d_addr, i_wdata, d_wdata, i_seed, d_seed;
  logic [BW-1:0] i_beat, d_beat;
  logic          i_rvalid, d_rvalid, i_done, d_done;
  logic [31:0]   i_rdata, d_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  arb_state_e    dbg_state;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   perf_i_bursts, perf_d_bursts, perf_wait_cycles;
`endif

  mem_refill_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata),
    .i_beat(i_beat), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_beat(d_beat), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef MEM_ARB_PERF_CNT_EN
    .perf_i_bursts(perf_i_bursts), .perf_d_bursts(perf_d_bursts),
    .perf_wait_cycles(perf_wait_cycles),
`endif
    .dbg_state(dbg_state)
  );

  // Each cache presents write data for the beat the arbiter names.
  assign i_wdata = i_seed + 32'(i_beat) * 32'h0101_0101;
  assign d_wdata = d_seed + 32'(d_beat) * 32'h0101_0101;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            lat      = 1;
  logic [64:0]   exp_mem_q[$];   // {we, addr, wdata-if-write}
  logic [33:0]   exp_ri_q[$];    // {beat, rdata}
  logic [33:0]   exp_rd_q[$];
  logic [0:0]    exp_done_q[$];  // owner in completion order
  logic [31:0]   mem_arr[256];
  logic [31:0]   ref_mem[256];
  logic          ref_last;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_cnt = 0;
  logic [64:0] hold_v;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        mem_cnt = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt == 1)
          hold_v = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
        else
          check("mem_hold", {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0}, hold_v);
        if (mem_cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
          mem_rdata = mem_arr[mem_addr[9:2]];
          mem_cnt   = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        if (exp_mem_q.size() == 0) check("mem_beat_unexpected", {1'b1, mem_addr}, 0);
        else check("mem_beat", {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0}, exp_mem_q.pop_front());
      end
      if (i_rvalid) begin
        if (exp_ri_q.size() == 0) check("i_rvalid_unexpected", i_rvalid, 0);
        else check("i_rdata", {i_beat, i_rdata}, exp_ri_q.pop_front());
      end
      if (d_rvalid) begin
        if (exp_rd_q.size() == 0) check("d_rvalid_unexpected", d_rvalid, 0);
        else check("d_rdata", {d_beat, d_rdata}, exp_rd_q.pop_front());
      end
      if (i_done || d_done) begin
        check("done_exclusive", {i_done, d_done} == 2'b11, 0);
        if (exp_done_q.size() == 0) check("done_unexpected", {i_done, d_done}, 0);
        else check("done_owner", d_done ? OWNER_D : OWNER_I, exp_done_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  // A burst covers the aligned line containing addr; writes land in order.
  task automatic push_burst(input logic owner, input logic [31:0] addr,
                            input logic we, input logic [31:0] seed);
    logic [31:0]   base, a, wd;
    logic [BW-1:0] kb;
    base = addr & ~32'(LW * 4 - 1);
    for (int k = 0; k < LW; k++) begin
      a  = base + 32'(k * 4);
      wd = seed + 32'(k) * 32'h0101_0101;
      kb = k[BW-1:0];
      if (we) begin
        exp_mem_q.push_back({1'b1, a, wd});
        ref_mem[a[9:2]] = wd;
      end else begin
        exp_mem_q.push_back({1'b0, a, 32'h0});
        if (owner == OWNER_I) exp_ri_q.push_back({kb, ref_mem[a[9:2]]});
        else                  exp_rd_q.push_back({kb, ref_mem[a[9:2]]});
      end
    end
    exp_done_q.push_back(owner);
    ref_last = owner;
  endtask

  // ---------------- driver ----------------
  task automatic run_phase(input bit use_i, input bit use_d,
                           input logic [31:0] ia, input logic [31:0] da,
                           input bit iwe, input bit dwe);
    int   edges, ndone, need;
    int   done_at[2];
    logic first;
    @(posedge clk);
    #1;
    i_addr = ia; i_we = iwe; i_seed = $urandom;
    d_addr = da; d_we = dwe; d_seed = $urandom;
    if (use_i && use_d) begin
      first = (ref_last == OWNER_I) ? OWNER_D : OWNER_I;
      if (first == OWNER_D) begin
        push_burst(OWNER_D, da, dwe, d_seed);
        push_burst(OWNER_I, ia, iwe, i_seed);
      end else begin
        push_burst(OWNER_I, ia, iwe, i_seed);
        push_burst(OWNER_D, da, dwe, d_seed);
      end
    end else if (use_i) begin
      push_burst(OWNER_I, ia, iwe, i_seed);
    end else if (use_d) begin
      push_burst(OWNER_D, da, dwe, d_seed);
    end
    i_req = use_i;
    d_req = use_d;
    need  = int'(use_i) + int'(use_d);
    check("mem_req_before_grant", mem_req, 0);
    edges = 0;
    ndone = 0;
    done_at[0] = 0;
    done_at[1] = 0;
    while (ndone < need && edges < MAX_WAIT) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) check("mem_req_after_grant", mem_req, 1);
      if (i_done && i_req) begin i_req = 1'b0; done_at[ndone] = edges; ndone++; end
      if (d_done && d_req) begin d_req = 1'b0; done_at[ndone] = edges; ndone++; end
    end
    if (ndone < need) check("burst_timeout", ndone, need);
    i_req = 1'b0;
    d_req = 1'b0;
    // With single-cycle acks: grant edge, LW beat edges, then DONE shows.
    if (lat == 1 && ndone == need) begin
      check("done_latency_first", done_at[0], LW + 1);
      if (need == 2) check("done_latency_second", done_at[1], 2 * LW + 3);
    end
  endtask

  // ---------------- stimulus ----------------
  int   sel;
  logic [31:0] ra, rb;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pi0, pd0, pw0;
`endif

  initial begin
    rst = 1'b1;
    i_req = 0; i_we = 0; i_addr = 0; i_seed = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_seed = 0;
    ref_last = OWNER_I;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req",  {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("reset_i_out",    {i_beat, i_rvalid, i_rdata, i_done}, 0);
    check("reset_d_out",    {d_beat, d_rvalid, d_rdata, d_done}, 0);
    check("reset_state",    dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {mem_req, dbg_state}, 0);

    // DCache line read at 0x100 with an ack every cycle.
    lat = 1;
    run_phase(0, 1, 32'h0, 32'h100, 0, 0);

    // Three simultaneous pairs; round-robin decides the order each time.
`ifdef MEM_ARB_PERF_CNT_EN
    pi0 = perf_i_bursts; pd0 = perf_d_bursts; pw0 = perf_wait_cycles;
`endif
    run_phase(1, 1, 32'h040, 32'h080, 0, 0);
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_i_bursts", perf_i_bursts - pi0, 1);
    check("perf_d_bursts", perf_d_bursts - pd0, 1);
    check("perf_wait_cycles", perf_wait_cycles - pw0, LW + 2);
`endif
    run_phase(1, 1, 32'h0C0, 32'h1C0, 0, 1);
    run_phase(1, 1, 32'h2C4, 32'h3C8, 1, 0);

    // Unaligned DCache write burst starting inside the line at 0x200.
    run_phase(0, 1, 32'h0, 32'h20C, 0, 1);
    run_phase(0, 1, 32'h0, 32'h200, 0, 0);

    // Slow memory: three cycles per beat.
    lat = 3;
    run_phase(1, 0, 32'h310, 32'h0, 0, 0);
    run_phase(1, 1, 32'h200, 32'h204, 0, 0);

    // Reset in the middle of a DCache burst, at beat 2.
    lat = 1;
    @(posedge clk);
    #1;
    d_addr = 32'h300; d_we = 1'b0; d_seed = $urandom;
    push_burst(OWNER_D, d_addr, 1'b0, d_seed);
    d_req = 1'b1;
    sel = 0;
    do begin
      @(negedge clk);
      sel++;
    end while (!(mem_req && mem_addr == 32'h308) && sel < MAX_WAIT);
    check("reach_beat2", {mem_req, mem_addr}, {1'b1, 32'h308});
    #2;
    rst = 1'b1;
    #1;
    check("abort_mem_req", {mem_req, mem_addr}, 0);
    check("abort_d_out", {d_beat, d_rvalid, d_done}, 0);
    check("abort_state", dbg_state, IDLE);
    d_req = 1'b0;
    exp_mem_q.delete();
    exp_ri_q.delete();
    exp_rd_q.delete();
    exp_done_q.delete();
    ref_last = OWNER_I;
    @(negedge clk);
    rst = 1'b0;
    run_phase(1, 0, 32'h384, 32'h0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      lat = $urandom_range(1, 3);
      sel = $urandom_range(0, 2);
      ra  = $urandom_range(0, 1023);
      rb  = $urandom_range(0, 1023);
      run_phase(sel != 1, sel != 0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queues_drained",
          exp_mem_q.size() + exp_ri_q.size() + exp_rd_q.size() + exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
